sm_gpio_port: RTL and testbench

SM_GPIO_PORT -- requirements
Module: sm_gpio_port

---
 rtl/sm_gpio_port.sv | 162 ++++++++++++++++
 tb/tb_sm_gpio_port.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_gpio_port.sv
// rtl/sm_gpio_port.sv - register-mapped GPIO port with input sync, edge capture and interrupt
//
// Ports:
//   clk     - single clock for all state
//   rst_n   - asynchronous active-low reset
//   bAddr   - register select (0 OUT, 1 DIR, 2 IN, 3 RISE_EN, 4 FALL_EN, 5 EDGE, 6 IRQ_EN, 7 reserved)
//   bWe     - write strobe, sampled on the rising clock edge
//   bWData  - write data
//   bRData  - combinational read data for bAddr
//   pad_i   - raw asynchronous pin inputs
//   pad_o   - registered pin output values (OUT)
//   pad_oe  - registered per-pin output enable (DIR, 1 = drive)
//   irq     - registered interrupt request, |(EDGE & IRQ_EN)

module sm_gpio_port #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       bAddr,
    input  logic             bWe,
    input  logic [31:0]      bWData,
    output logic [31:0]      bRData,
    input  logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] pad_o,
    output logic [WIDTH-1:0] pad_oe,
    output logic             irq
);

    localparam logic [2:0] ADDR_OUT     = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IN      = 3'd2;
    localparam logic [2:0] ADDR_RISE_EN = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN = 3'd4;
    localparam logic [2:0] ADDR_EDGE    = 3'd5;
    localparam logic [2:0] ADDR_IRQ_EN  = 3'd6;

    // Edge detection is held off until the sync chain and PREV have both
    // been filled from the pins, so a pin that is already high when reset
    // releases is not mistaken for a rising edge.
    localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] rise_en_q;
    logic [WIDTH-1:0] fall_en_q;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] irq_en_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [2:0]       warm_q;
    logic             irq_q;

    logic [WIDTH-1:0] in_w;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] edge_next;
    logic [WIDTH-1:0] rdata_w;
    logic             warm_done;
    logic             wr_out;
    logic             wr_dir;
    logic             wr_rise_en;
    logic             wr_fall_en;
    logic             wr_irq_en;
    logic             unused_wdata;

    // Upper write-data bits beyond WIDTH have no storage behind them.
    assign unused_wdata = ^bWData;

    assign in_w    = sync_q[SYNC_STAGES-1];
    assign wr_data = bWData[WIDTH-1:0];

    assign wr_out     = bWe && (bAddr == ADDR_OUT);
    assign wr_dir     = bWe && (bAddr == ADDR_DIR);
    assign wr_rise_en = bWe && (bAddr == ADDR_RISE_EN);
    assign wr_fall_en = bWe && (bAddr == ADDR_FALL_EN);
    assign wr_irq_en  = bWe && (bAddr == ADDR_IRQ_EN);

    assign warm_done = (warm_q == WARM_DONE);
    assign rise_w    = in_w & ~prev_q;
    assign fall_w    = ~in_w & prev_q;

    // rise/fall are single-cycle pulses, so an enable written later never
    // picks up an edge that already went by.
    assign edge_set  = warm_done ? ((rise_w & rise_en_q) | (fall_w & fall_en_q)) : '0;
    assign edge_clr  = (bWe && (bAddr == ADDR_EDGE)) ? wr_data : '0;
    // Clear first, then set, so a new edge in the clearing cycle survives.
    assign edge_next = (edge_q & ~edge_clr) | edge_set;

    assign pad_o  = out_q;
    assign pad_oe = dir_q;
    assign irq    = irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= pad_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            warm_q <= '0;
        end else begin
            prev_q <= in_w;
            if (!warm_done) begin
                warm_q <= warm_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            irq_en_q  <= '0;
            edge_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            if (wr_out)     out_q     <= wr_data;
            if (wr_dir)     dir_q     <= wr_data;
            if (wr_rise_en) rise_en_q <= wr_data;
            if (wr_fall_en) fall_en_q <= wr_data;
            if (wr_irq_en)  irq_en_q  <= wr_data;
            edge_q <= edge_next;
            irq_q  <= |(edge_q & irq_en_q);
        end
    end

    always_comb begin
        rdata_w = '0;
        case (bAddr)
            ADDR_OUT:     rdata_w = out_q;
            ADDR_DIR:     rdata_w = dir_q;
            ADDR_IN:      rdata_w = in_w;
            ADDR_RISE_EN: rdata_w = rise_en_q;
            ADDR_FALL_EN: rdata_w = fall_en_q;
            ADDR_EDGE:    rdata_w = edge_q;
            ADDR_IRQ_EN:  rdata_w = irq_en_q;
            default:      rdata_w = '0;
        endcase
    end

    always_comb begin
        bRData = '0;
        bRData[WIDTH-1:0] = rdata_w;
    end

endmodule

// File: tb/tb_sm_gpio_port.sv
// tb/tb_sm_gpio_port.sv - self-checking bench for sm_gpio_port against a behavioural model

module tb_sm_gpio_port;

    localparam int W = 8;
    localparam int S = 3;

    logic         clk;
    logic         rst_n;
    logic [2:0]   bAddr;
    logic         bWe;
    logic [31:0]  bWData;
    logic [31:0]  bRData;
    logic [W-1:0] pad_i;
    logic [W-1:0] pad_o;
    logic [W-1:0] pad_oe;
    logic         irq;

    int total = 0;
    int bad   = 0;

    sm_gpio_port #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bAddr  (bAddr),
        .bWe    (bWe),
        .bWData (bWData),
        .bRData (bRData),
        .pad_i  (pad_i),
        .pad_o  (pad_o),
        .pad_oe (pad_oe),
        .irq    (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: register file plus a short history of pin samples.
    logic [W-1:0] m_out, m_dir, m_rise_en, m_fall_en, m_edge, m_irq_en;
    logic [W-1:0] m_in, m_prev;
    logic         m_irq;
    int           m_n;
    logic [W-1:0] samp[$];

    always @(posedge clk or negedge rst_n) begin
        logic [W-1:0] set_b, clr_b;
        logic         irq_nx;
        if (!rst_n) begin
            m_out = '0; m_dir = '0; m_rise_en = '0; m_fall_en = '0;
            m_edge = '0; m_irq_en = '0; m_in = '0; m_prev = '0;
            m_irq = 1'b0; m_n = 0;
            samp.delete();
        end else begin
            if (m_n < 1000) m_n = m_n + 1;
            set_b = '0;
            // Edges are only trusted once S sync edges plus one PREV edge have passed.
            if (m_n >= S + 2)
                set_b = (m_in & ~m_prev & m_rise_en) | (~m_in & m_prev & m_fall_en);
            irq_nx = |(m_edge & m_irq_en);
            clr_b = '0;
            if (bWe) begin
                case (bAddr)
                    3'd0: m_out     = bWData[W-1:0];
                    3'd1: m_dir     = bWData[W-1:0];
                    3'd3: m_rise_en = bWData[W-1:0];
                    3'd4: m_fall_en = bWData[W-1:0];
                    3'd5: clr_b     = bWData[W-1:0];
                    3'd6: m_irq_en  = bWData[W-1:0];
                    default: ;
                endcase
            end
            m_edge = (m_edge & ~clr_b) | set_b;
            m_irq  = irq_nx;
            samp.push_back(pad_i);
            if (samp.size() > S) void'(samp.pop_front());
            m_prev = m_in;
            m_in   = (samp.size() == S) ? samp[0] : '0;
        end
    end

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            3'd0: r[W-1:0] = m_out;
            3'd1: r[W-1:0] = m_dir;
            3'd2: r[W-1:0] = m_in;
            3'd3: r[W-1:0] = m_rise_en;
            3'd4: r[W-1:0] = m_fall_en;
            3'd5: r[W-1:0] = m_edge;
            3'd6: r[W-1:0] = m_irq_en;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("pad_o",  32'(pad_o),  32'(m_out));
        chk("pad_oe", 32'(pad_oe), 32'(m_dir));
        chk("irq",    32'(irq),    32'(m_irq));
        chk("rdata",  bRData,      m_read(bAddr));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bAddr  = a;
        bWData = d;
        bWe    = 1'b1;
        tick();
        bWe    = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        bWe   = 1'b0;
        bAddr = a;
        #1;
        d = bRData;
    endtask

    logic [31:0] v;

    initial begin
        rst_n  = 1'b0;
        bAddr  = 3'd0;
        bWe    = 1'b0;
        bWData = '0;
        pad_i  = 8'hFF;
        ticks(3);
        chk("reset pad_o",  32'(pad_o),  32'h0);
        chk("reset pad_oe", 32'(pad_oe), 32'h0);
        chk("reset irq",    32'(irq),    32'h0);

        // Pins high across reset release: no false rise.
        rst_n = 1'b1;
        wr(3'd3, 32'hFF);
        wr(3'd6, 32'hFF);
        ticks(10);
        rd(3'd5, v);
        chk("warmup edge", v, 32'h0);
        chk("warmup irq", 32'(irq), 32'h0);

        // OUT/DIR drive pins on the write clock.
        wr(3'd0, 32'hA5);
        wr(3'd1, 32'h0F);
        chk("pad_o A5",  32'(pad_o),  32'hA5);
        chk("pad_oe 0F", 32'(pad_oe), 32'h0F);
        rd(3'd0, v);
        chk("read OUT", v, 32'h0000_00A5);

        // Sync latency, edge capture and irq timing for a single rise.
        wr(3'd3, 32'h01);
        wr(3'd6, 32'h01);
        pad_i = 8'h00;
        ticks(6);
        wr(3'd5, 32'hFF);
        pad_i = 8'h01;
        ticks(2);
        rd(3'd2, v);
        chk("IN before latency", v, 32'h0);
        tick();
        rd(3'd2, v);
        chk("IN after 3 clk", v, 32'h01);
        rd(3'd5, v);
        chk("EDGE not yet", v, 32'h0);
        tick();
        rd(3'd5, v);
        chk("EDGE set", v, 32'h01);
        chk("irq not yet", 32'(irq), 32'h0);
        tick();
        chk("irq set", 32'(irq), 32'h1);

        // Set wins over a simultaneous clear.
        wr(3'd5, 32'hFF);
        wr(3'd3, 32'h03);
        pad_i = 8'h00;
        ticks(6);
        pad_i = 8'h03;
        ticks(5);
        rd(3'd5, v);
        chk("EDGE 03", v, 32'h03);
        pad_i = 8'h00;
        ticks(5);
        pad_i = 8'h01;
        ticks(3);
        wr(3'd5, 32'h03);
        rd(3'd5, v);
        chk("set wins", v, 32'h01);

        // Falling edge capture, IN read-only, upper bits zero.
        wr(3'd3, 32'h00);
        wr(3'd4, 32'h80);
        pad_i = 8'h80;
        ticks(5);
        wr(3'd5, 32'hFF);
        pad_i = 8'h00;
        ticks(5);
        rd(3'd5, v);
        chk("EDGE fall7", v, 32'h80);
        wr(3'd2, 32'hFFFF_FFFF);
        rd(3'd2, v);
        chk("IN ro", v, 32'h0);
        wr(3'd0, 32'hFFFF_FFFF);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), v);
            chk("upper zero", {8'h0, v[31:8]}, 32'h0);
        end

        // Randomised traffic, checked every cycle by the compare process.
        for (int i = 0; i < 600; i++) begin
            bAddr  = 3'($urandom_range(0, 7));
            bWe    = ($urandom_range(0, 2) == 0);
            bWData = $urandom;
            if ($urandom_range(0, 3) == 0) pad_i = 8'($urandom);
            tick();
        end
        bWe = 1'b0;

        // Async reset while irq is high.
        wr(3'd6, 32'hFF);
        wr(3'd3, 32'hFF);
        wr(3'd1, 32'hFF);
        wr(3'd5, 32'hFF);
        pad_i = 8'h00;
        ticks(6);
        wr(3'd5, 32'hFF);
        pad_i = 8'hFF;
        ticks(6);
        chk("irq before rst", 32'(irq), 32'h1);
        bAddr = 3'd5;
        #1;
        rst_n = 1'b0;
        #1;
        chk("async irq",    32'(irq),    32'h0);
        chk("async pad_oe", 32'(pad_oe), 32'h0);
        chk("async edge",   bRData,      32'h0);
        #1;
        rst_n = 1'b1;
        ticks(10);
        rd(3'd5, v);
        chk("post rst edge", v, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
